issue_sched: RTL

- Registered issue scheduler between the fetch window (two sequential 32-bit instructions) and the two decode/execute lanes of the dual-issue MIPS pipeline.
- Each cycle it decides whether the older/younger candidate pair may issue together.
- On a conflict it defers the younger instruction into a one-entry hold register. It tells fetch how many window instructions were consumed (0/1/2), which replaces the PC rewind.
- It handles downstream stall, redirect flush and pairing performance counters.

---
 rtl/issue_pkg.sv | 28 ++
 rtl/pair_check.sv | 43 ++++
 rtl/issue_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scheduler: the packed attribute
// layout produced by the pre-decoder, the scheduler state encoding and the
// fetch-consume codes.
package issue_pkg;

  // Attribute bus, MSB to LSB:
  // ctrl | mem | rw | dst[4:0] | src_a[4:0] | src_b[4:0] | uses_b
  localparam int unsigned ATTR_W     = 19;
  localparam int unsigned A_CTRL     = 18;
  localparam int unsigned A_MEM      = 17;
  localparam int unsigned A_RW       = 16;
  localparam int unsigned A_DST_LSB  = 11;
  localparam int unsigned A_SRCA_LSB = 6;
  localparam int unsigned A_SRCB_LSB = 1;
  localparam int unsigned A_USES_B   = 0;
  localparam int unsigned REG_W      = 5;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } sched_state_e;

  // Number of fetch-window instructions consumed in a cycle.
  localparam logic [1:0] CONS_NONE = 2'd0;
  localparam logic [1:0] CONS_ONE  = 2'd1;
  localparam logic [1:0] CONS_TWO  = 2'd2;

endpackage

// File: rtl/pair_check.sv
// Combinational pairing check for an older/younger instruction pair.
// Ports:
//   o_attr_i   - attributes of the older instruction
//   y_attr_i   - attributes of the younger instruction
//   pairable_o - 1 when both may issue in the same cycle
module pair_check
  import issue_pkg::*;
(
  input  logic [ATTR_W-1:0] o_attr_i,
  input  logic [ATTR_W-1:0] y_attr_i,
  output logic              pairable_o
);

  logic             o_ctrl_s, o_mem_s, o_rw_s;
  logic             y_ctrl_s, y_mem_s, y_rw_s, y_uses_b_s;
  logic [REG_W-1:0] o_dst_s, y_dst_s, y_srca_s, y_srcb_s;
  logic             o_dst_nz_s;
  logic             ctrl_hz_s, mem_hz_s, raw_hz_s, waw_hz_s;

  assign o_ctrl_s   = o_attr_i[A_CTRL];
  assign o_mem_s    = o_attr_i[A_MEM];
  assign o_rw_s     = o_attr_i[A_RW];
  assign o_dst_s    = o_attr_i[A_DST_LSB +: REG_W];
  assign y_ctrl_s   = y_attr_i[A_CTRL];
  assign y_mem_s    = y_attr_i[A_MEM];
  assign y_rw_s     = y_attr_i[A_RW];
  assign y_dst_s    = y_attr_i[A_DST_LSB +: REG_W];
  assign y_srca_s   = y_attr_i[A_SRCA_LSB +: REG_W];
  assign y_srcb_s   = y_attr_i[A_SRCB_LSB +: REG_W];
  assign y_uses_b_s = y_attr_i[A_USES_B];

  // $zero is never a real producer, so it cannot create RAW/WAW hazards.
  assign o_dst_nz_s = (o_dst_s != 5'd0);

  assign ctrl_hz_s = o_ctrl_s | y_ctrl_s;
  assign mem_hz_s  = o_mem_s & y_mem_s;
  assign raw_hz_s  = o_rw_s & o_dst_nz_s &
                     ((y_srca_s == o_dst_s) | (y_uses_b_s & (y_srcb_s == o_dst_s)));
  assign waw_hz_s  = o_rw_s & y_rw_s & o_dst_nz_s & (o_dst_s == y_dst_s);

  assign pairable_o = ~(ctrl_hz_s | mem_hz_s | raw_hz_s | waw_hz_s);

endmodule

// File: rtl/issue_sched.sv
// Registered dual-issue scheduler between the two-instruction fetch window
// and the two decode/execute lanes. A younger instruction that cannot pair
// is parked in a one-entry hold register and issued as the older lane next.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   f_valid               - fetch window holds two valid instructions
//   f_inst0/1, f_attr0/1  - window instructions (PC, PC+4) and attributes
//   stall_in, flush_in    - downstream stall, redirect flush
//   f_consume             - window instructions consumed this cycle (comb)
//   iss0_*/iss1_*         - registered lane 0 (older) / lane 1 (younger)
//   pair_cnt, single_cnt  - dual-issue / single-issue cycle counters
module issue_sched
  import issue_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [31:0]       f_inst0,
  input  logic [31:0]       f_inst1,
  input  logic [ATTR_W-1:0] f_attr0,
  input  logic [ATTR_W-1:0] f_attr1,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic [1:0]        f_consume,
  output logic              iss0_valid,
  output logic [31:0]       iss0_inst,
  output logic              iss1_valid,
  output logic [31:0]       iss1_inst,
  output logic [CNT_W-1:0]  pair_cnt,
  output logic [CNT_W-1:0]  single_cnt
);

  sched_state_e      state_q, state_d;
  logic [31:0]       hold_inst_q, hold_inst_d;
  logic [ATTR_W-1:0] hold_attr_q, hold_attr_d;
  logic              iss0_valid_q, iss0_valid_d;
  logic              iss1_valid_q, iss1_valid_d;
  logic [31:0]       iss0_inst_q, iss0_inst_d;
  logic [31:0]       iss1_inst_q, iss1_inst_d;
  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0]  single_cnt_q, single_cnt_d;
  logic [1:0]        consume_s;
  logic              pair_win_s, pair_hold_s;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pair_check u_pair_win (
    .o_attr_i   (f_attr0),
    .y_attr_i   (f_attr1),
    .pairable_o (pair_win_s)
  );

  pair_check u_pair_hold (
    .o_attr_i   (hold_attr_q),
    .y_attr_i   (f_attr0),
    .pairable_o (pair_hold_s)
  );

  // Next-state, issue selection and counter update.
  always_comb begin
    state_d      = state_q;
    hold_inst_d  = hold_inst_q;
    hold_attr_d  = hold_attr_q;
    iss0_valid_d = iss0_valid_q;
    iss1_valid_d = iss1_valid_q;
    iss0_inst_d  = iss0_inst_q;
    iss1_inst_d  = iss1_inst_q;
    pair_cnt_d   = pair_cnt_q;
    single_cnt_d = single_cnt_q;
    consume_s    = CONS_NONE;

    if (flush_in) begin
      state_d      = ST_RUN;
      hold_inst_d  = 32'd0;
      hold_attr_d  = '0;
      iss0_valid_d = 1'b0;
      iss1_valid_d = 1'b0;
    end else if (stall_in) begin
      // Everything already holds its current value.
      consume_s = CONS_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (f_valid) begin
            iss0_valid_d = 1'b1;
            iss0_inst_d  = f_inst0;
            consume_s    = CONS_TWO;
            if (pair_win_s) begin
              iss1_valid_d = 1'b1;
              iss1_inst_d  = f_inst1;
            end else begin
              // f_inst1 is consumed now but issued next cycle from hold.
              iss1_valid_d = 1'b0;
              hold_inst_d  = f_inst1;
              hold_attr_d  = f_attr1;
              state_d      = ST_HELD;
            end
          end else begin
            iss0_valid_d = 1'b0;
            iss1_valid_d = 1'b0;
          end
        end
        ST_HELD: begin
          // The held instruction is older than anything in the window.
          iss0_valid_d = 1'b1;
          iss0_inst_d  = hold_inst_q;
          hold_inst_d  = 32'd0;
          hold_attr_d  = '0;
          state_d      = ST_RUN;
          if (f_valid && pair_hold_s) begin
            iss1_valid_d = 1'b1;
            iss1_inst_d  = f_inst0;
            consume_s    = CONS_ONE;
          end else begin
            iss1_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = ST_RUN;
          iss0_valid_d = 1'b0;
          iss1_valid_d = 1'b0;
        end
      endcase

      if (iss0_valid_d && iss1_valid_d) begin
        pair_cnt_d = pair_cnt_q + CNT_ONE;
      end else if (iss0_valid_d) begin
        single_cnt_d = single_cnt_q + CNT_ONE;
      end else begin
        pair_cnt_d = pair_cnt_q;
      end
    end
  end

  // Scheduler state, hold entry, issue lanes and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      hold_inst_q  <= 32'd0;
      hold_attr_q  <= '0;
      iss0_valid_q <= 1'b0;
      iss1_valid_q <= 1'b0;
      iss0_inst_q  <= 32'd0;
      iss1_inst_q  <= 32'd0;
      pair_cnt_q   <= '0;
      single_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_inst_q  <= hold_inst_d;
      hold_attr_q  <= hold_attr_d;
      iss0_valid_q <= iss0_valid_d;
      iss1_valid_q <= iss1_valid_d;
      iss0_inst_q  <= iss0_inst_d;
      iss1_inst_q  <= iss1_inst_d;
      pair_cnt_q   <= pair_cnt_d;
      single_cnt_q <= single_cnt_d;
    end
  end

  // Fetch must see nothing consumed while reset is held.
  assign f_consume  = reset ? CONS_NONE : consume_s;
  assign iss0_valid = iss0_valid_q;
  assign iss0_inst  = iss0_inst_q;
  assign iss1_valid = iss1_valid_q;
  assign iss1_inst  = iss1_inst_q;
  assign pair_cnt   = pair_cnt_q;
  assign single_cnt = single_cnt_q;

endmodule
